// File: rtl/enigma_rotor_core.sv
// Rotor-keyed involutive symbol cipher with a two-stage valid/ready pipeline.
// Define ENIGMA_DOUBLE_STEP_EN to enable the rotor-1 notch double-step anomaly.
module enigma_rotor_core #(
    parameter int SYMB_W = 7,
    parameter int ALPHA  = 26,
    parameter int ROTORS = 3,
    parameter int REFL   = 13,
    parameter int CNT_W  = 8,
    localparam int POS_W = $clog2(ALPHA)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    rotors_rst_i,
    input  logic [ROTORS*POS_W-1:0] key_pos_i,
    input  logic [CNT_W-1:0]        symb_numb_i,
    input  logic                    symb_val_i,
    output logic                    symb_rdy_o,
    input  logic [SYMB_W-1:0]       symbol_i,
    output logic                    symb_val_o,
    input  logic                    symb_rdy_i,
    output logic [SYMB_W-1:0]       symbol_o,
    output logic                    msg_done_o
);

    function automatic logic [POS_W-1:0] inc_mod(input logic [POS_W-1:0] p);
        return (p == POS_W'(ALPHA - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [ROTORS*POS_W-1:0] step_rotors(input logic [ROTORS*POS_W-1:0] cur);
        logic [ROTORS*POS_W-1:0] nxt;
        logic                    carry;
        logic                    notch;
        nxt   = cur;
        carry = 1'b1;
        notch = 1'b0;
        for (int i = 0; i < ROTORS; i++) begin
            if (carry) begin
                nxt[i*POS_W +: POS_W] = inc_mod(cur[i*POS_W +: POS_W]);
                carry = (cur[i*POS_W +: POS_W] == POS_W'(ALPHA - 1));
            end
        end
`ifdef ENIGMA_DOUBLE_STEP_EN
        // Notch sensed on rotor 1 before stepping drags rotors 1 and 2 one extra place.
        for (int i = 1; i < ROTORS && i < 2; i++)
            notch = (cur[i*POS_W +: POS_W] == POS_W'(ALPHA - 1));
        for (int i = 1; i < ROTORS && i < 3; i++)
            if (ROTORS >= 3 && notch)
                nxt[i*POS_W +: POS_W] = inc_mod(nxt[i*POS_W +: POS_W]);
`endif
        return nxt;
    endfunction

    function automatic logic [POS_W-1:0] key_sum(input logic [ROTORS*POS_W-1:0] pos);
        int acc;
        acc = 0;
        for (int i = 0; i < ROTORS; i++)
            acc = acc + int'(pos[i*POS_W +: POS_W]) * (2 * i + 1);
        return POS_W'(acc % ALPHA);
    endfunction

    function automatic logic [SYMB_W-1:0] encrypt(input logic [SYMB_W-1:0] sym,
                                                  input logic [POS_W-1:0]  key);
        logic signed [31:0] d;
        d = REFL - int'(sym) - 2 * int'(key);
        d = d % ALPHA;
        if (d < 0) d = d + ALPHA;
        return SYMB_W'(d);
    endfunction

    logic [ROTORS*POS_W-1:0] rot_q, rot_step;
    logic [CNT_W-1:0]        cnt_q, numb_q, lim;
    logic                    drop_q, rdy_en;
    logic                    vld_p1, last_p1, rng_p1;
    logic [SYMB_W-1:0]       sym_p1;
    logic [POS_W-1:0]        key_p1;
    logic                    vld_p2, last_p2;
    logic [SYMB_W-1:0]       sym_p2;
    logic                    adv2, s1_free, acc, take, in_rng, is_last, done;

    assign adv2       = !vld_p2 || symb_rdy_i;
    assign s1_free    = !vld_p1 || adv2;
    assign symb_rdy_o = rdy_en && !rotors_rst_i && (drop_q || s1_free);
    assign acc        = symb_val_i && symb_rdy_o;
    assign take       = acc && !drop_q;
    assign in_rng     = (int'(symbol_i) < ALPHA);
    assign rot_step   = step_rotors(rot_q);
    // The message length is latched on the first symbol but must apply to that symbol too.
    assign lim        = (cnt_q == '0) ? symb_numb_i : numb_q;
    assign is_last    = (lim != '0) && (cnt_q + CNT_W'(1) == lim);
    assign done       = vld_p2 && symb_rdy_i && last_p2;
    assign msg_done_o = done;
    assign symb_val_o = vld_p2;
    assign symbol_o   = sym_p2;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rdy_en <= 1'b0;
            rot_q  <= '0;
            cnt_q  <= '0;
            numb_q <= '0;
            drop_q <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (rotors_rst_i || done)
                rot_q <= key_pos_i;
            else if (take && in_rng)
                rot_q <= rot_step;
            if (rotors_rst_i || done)
                cnt_q <= '0;
            else if (take && lim != '0)
                cnt_q <= cnt_q + CNT_W'(1);
            if (take && cnt_q == '0)
                numb_q <= symb_numb_i;
            if (rotors_rst_i)
                drop_q <= 1'b0;
            else if (take && is_last)
                drop_q <= 1'b1;
        end
    end

    // Stage 1: register symbol and the key of the freshly stepped rotors
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end else if (s1_free) begin
            vld_p1  <= take;
            last_p1 <= take && is_last;
        end
    end

    always_ff @(posedge clk_i) begin
        if (take) begin
            sym_p1 <= symbol_i;
            key_p1 <= key_sum(rot_step);
            rng_p1 <= in_rng;
        end
    end

    // Stage 2: register the encrypted (or passed-through) output symbol
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            vld_p2  <= 1'b0;
            last_p2 <= 1'b0;
            sym_p2  <= '0;
        end else if (adv2) begin
            vld_p2  <= vld_p1;
            last_p2 <= vld_p1 && last_p1;
            if (vld_p1)
                sym_p2 <= rng_p1 ? encrypt(sym_p1, key_p1) : sym_p1;
        end
    end

endmodule

// File: tb/tb_enigma_rotor_core.sv
// Scoreboard bench for enigma_rotor_core: directed vectors, queue of expected outputs,
// independent monitor popping on every output transfer.
module tb_enigma_rotor_core;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        rotors_rst_i = 1'b0;
    logic [14:0] key_pos_i = '0;
    logic [7:0]  symb_numb_i = '0;
    logic        symb_val_i = 1'b0;
    logic        symb_rdy_o;
    logic [6:0]  symbol_i = '0;
    logic        symb_val_o;
    logic        symb_rdy_i = 1'b1;
    logic [6:0]  symbol_o;
    logic        msg_done_o;

    enigma_rotor_core dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .rotors_rst_i(rotors_rst_i),
        .key_pos_i   (key_pos_i),
        .symb_numb_i (symb_numb_i),
        .symb_val_i  (symb_val_i),
        .symb_rdy_o  (symb_rdy_o),
        .symbol_i    (symbol_i),
        .symb_val_o  (symb_val_o),
        .symb_rdy_i  (symb_rdy_i),
        .symbol_o    (symbol_o),
        .msg_done_o  (msg_done_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int sym;
        bit done;
        int acc;
        bit lat;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_i && symb_val_o && symb_rdy_i) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", int'(symbol_o), -1);
                end else begin
                    e = q.pop_front();
                    chk("out_symbol", int'(symbol_o), e.sym);
                    chk("out_msg_done", int'(msg_done_o), int'(e.done));
                    if (e.lat) chk("out_latency", cyc + 1 - e.acc, 2);
                end
            end else if (msg_done_o) begin
                chk("spurious_msg_done", 1, 0);
            end
        end
    end

    task automatic send(input int s, input int exp, input bit dn, input bit push, input bit lat);
        bit   ok;
        int   acc_e;
        exp_t e;
        ok = 1'b0;
        acc_e = 0;
        @(negedge clk);
        symb_val_i = 1'b1;
        symbol_i   = 7'(s);
        for (int b = 0; b < 100; b++) begin
            #1;
            ok = symb_rdy_o;
            acc_e = cyc + 1;
            @(posedge clk);
            if (ok) break;
            @(negedge clk);
        end
        #1;
        symb_val_i = 1'b0;
        if (!ok) begin
            chk("send_timeout", 0, 1);
        end else if (push) begin
            e.sym = exp; e.done = dn; e.acc = acc_e; e.lat = lat;
            q.push_back(e);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || symb_val_o) && n < 100) begin
            @(negedge clk);
            #3;
            n++;
        end
        chk("drain_queue_empty", q.size(), 0);
    endtask

    task automatic rrst();
        @(negedge clk);
        rotors_rst_i = 1'b1;
        #1;
        chk("rotors_rst_rdy_low", int'(symb_rdy_o), 0);
        @(negedge clk);
        rotors_rst_i = 1'b0;
    endtask

    task automatic check_rot(input string name, input int r0, input int r1, input int r2);
        chk(name, int'(dut.rot_q), (r2 << 10) | (r1 << 5) | r0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_i = 1'b1;
        #1;
        chk("rdy_low_at_release", int'(symb_rdy_o), 0);
        @(posedge clk);
        #1;
        chk("rdy_high_after_first_clk", int'(symb_rdy_o), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int exp8[8] = '{11, 8, 5, 2, 25, 22, 19, 16};
    int exp4[4] = '{5, 2, 25, 22};

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_rdy", int'(symb_rdy_o), 0);
        chk("rst_val", int'(symb_val_o), 0);
        chk("rst_symbol", int'(symbol_o), 0);
        chk("rst_done", int'(msg_done_o), 0);
        release_reset();

        // key (0,0,0): 0,0 -> 11,9 at 2-cycle latency
        key_pos_i = '0;
        rrst();
        send(0, 11, 1'b0, 1'b1, 1'b1);
        send(0, 9, 1'b0, 1'b1, 1'b1);
        drain();

        // involution: 11,9 -> 0,0
        rrst();
        send(11, 0, 1'b0, 1'b1, 1'b1);
        send(9, 0, 1'b0, 1'b1, 1'b1);
        drain();

        // carry from rotor 0 into rotor 1, then out-of-alphabet pass-through
        key_pos_i = {5'd0, 5'd0, 5'd25};
        rrst();
        send(0, 7, 1'b0, 1'b1, 1'b1);
        drain();
        check_rot("rot_after_carry", 0, 1, 0);
        send(30, 30, 1'b0, 1'b1, 1'b1);
        drain();
        check_rot("rot_after_passthru", 0, 1, 0);

        // 8-symbol stream with a 5-cycle output stall
        key_pos_i = '0;
        rrst();
        fork
            begin
                for (int i = 0; i < 8; i++) send(i, exp8[i], 1'b0, 1'b1, 1'b0);
            end
            begin
                repeat (3) @(negedge clk);
                symb_rdy_i = 1'b0;
                repeat (4) @(negedge clk);
                #1;
                chk("stall_rdy_low", int'(symb_rdy_o), 0);
                @(negedge clk);
                symb_rdy_i = 1'b1;
            end
        join
        drain();

        // 4-symbol message, 6 sent: last two dropped, rotors reload key (3,0,0)
        key_pos_i   = {5'd0, 5'd0, 5'd3};
        symb_numb_i = 8'd4;
        rrst();
        for (int i = 0; i < 4; i++) send(i, exp4[i], (i == 3), 1'b1, 1'b0);
        send(4, 0, 1'b0, 1'b0, 1'b0);
        send(5, 0, 1'b0, 1'b0, 1'b0);
        drain();
        check_rot("rot_reload_after_msg", 3, 0, 0);
        symb_numb_i = 8'd0;

        // rotor 1 at notch
        key_pos_i = {5'd0, 5'd25, 5'd0};
        rrst();
`ifdef ENIGMA_DOUBLE_STEP_EN
        send(0, 1, 1'b0, 1'b1, 1'b1);
        drain();
        check_rot("rot_notch", 1, 0, 1);
`else
        send(0, 17, 1'b0, 1'b1, 1'b1);
        drain();
        check_rot("rot_notch", 1, 25, 0);
`endif

        // reset with a symbol in flight discards it
        send(2, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        chk("midrst_val", int'(symb_val_o), 0);
        chk("midrst_rdy", int'(symb_rdy_o), 0);
        check_rot("midrst_rot", 0, 0, 0);
        repeat (2) @(negedge clk);
        release_reset();
        repeat (5) @(negedge clk);
        chk("midrst_no_output_queue", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/enigma_rotor_core.md
ENIGMA_ROTOR_CORE -- requirements
Module: enigma_rotor_core

Interface
REQ-001 SHALL have parameter SYMB_W, default 7, symbol width in bits.
REQ-002 SHALL have parameter ALPHA, default 26, alphabet size (2..2**SYMB_W).
REQ-003 SHALL have parameter ROTORS, default 3, rotor count (1..8).
REQ-004 SHALL have parameter REFL, default 13, reflector constant (0..ALPHA-1).
REQ-005 SHALL have parameter CNT_W, default 8, message-length counter width; POS_W = $clog2(ALPHA).
REQ-006 clk_i  in  1  sole clock, rising edge.
REQ-007 rst_i  in  1  reset, asynchronous, active-low.
REQ-008 rotors_rst_i  in  1  synchronous reload of rotors from key_pos_i and clear of symbol counter.
REQ-009 key_pos_i  in  ROTORS*POS_W  start positions; rotor i at bits [i*POS_W +: POS_W].
REQ-010 symb_numb_i  in  CNT_W  symbols per message; 0 = unlimited.
REQ-011 symb_val_i / symb_rdy_o  in / out  1 / 1  input handshake; transfer when both are high.
REQ-012 symbol_i  in  SYMB_W  unsigned input symbol.
REQ-013 symb_val_o / symb_rdy_i  out / in  1 / 1  output handshake; transfer when both are high.
REQ-014 symbol_o  out  SYMB_W  encrypted symbol.
REQ-015 msg_done_o  out  1  one-cycle pulse on transfer of the last symbol of a message.

Function
REQ-016 On each accepted symbol with value < ALPHA, rotors SHALL step before encryption: rotor 0 +1 mod ALPHA; rotor i+1 +1 when rotor i wraps from ALPHA-1 to 0.
REQ-017 Stepped key S = sum(pos_i*(2i+1)) mod ALPHA; symbol_o = (REFL - symbol_i - 2S) mod ALPHA, making encryption an involution.
REQ-018 Symbols >= ALPHA SHALL pass through unchanged, SHALL NOT step rotors, and SHALL count toward symb_numb_i.
REQ-019 Datapath SHALL be a 2-stage pipeline: stage 1 registers symbol and S, stage 2 registers symbol_o; latency 2 cycles without stall.
REQ-020 Each stage SHALL advance when empty or when its successor accepts; symb_rdy_o = !stage1_full or stage1 advancing; full throughput 1 symbol/cycle.
REQ-021 symb_val_o/symbol_o SHALL hold stable while symb_val_o=1 and symb_rdy_i=0; no symbol lost or duplicated.
REQ-022 symb_numb_i SHALL be sampled on the first accepted symbol of a message; after that many accepted symbols, further symbols are dropped (symb_rdy_o high, nothing emitted) until rotors_rst_i.
REQ-023 On output transfer of the message's last symbol, msg_done_o SHALL pulse one cycle; rotors reload key_pos_i on that same cycle's edge and counter clears.
REQ-024 rotors_rst_i SHALL force symb_rdy_o low that cycle; rotors_rst_i wins over acceptance; symbols already in the pipeline complete unchanged.
REQ-025 Counter SHALL not wrap; symb_numb_i = 0 disables counting and msg_done_o.

Reset
REQ-026 While rst_i=0: rotors=0, counter=0, both stages empty, symb_val_o=0, symbol_o=0, msg_done_o=0, symb_rdy_o=0.
REQ-027 Reset mid-message SHALL discard in-flight symbols; symb_rdy_o SHALL rise the first clock after release.

Configuration
REQ-028 Macro ENIGMA_DOUBLE_STEP_EN defined: when rotor 1 is at ALPHA-1 (notch) at a step, rotor 1 and rotor 2 both step additionally (double-step anomaly; ROTORS >= 3).
REQ-029 Macro undefined: pure odometer stepping per REQ-016.

Verification (defaults ALPHA=26, ROTORS=3, REFL=13)
REQ-030 Key (0,0,0), send 0,0, symb_rdy_i=1 -> symbol_o 11 then 9, each 2 cycles after acceptance.
REQ-031 rotors_rst_i, then send 11, 9 -> symbol_o 0, 0 (involution).
REQ-032 Key (25,0,0), send 0 -> rotors (0,1,0), symbol_o 7; send 30 -> symbol_o 30, rotors unchanged.
REQ-033 Stream 8 symbols, symb_rdy_i low 5 cycles mid-stream -> symb_rdy_o falls once both stages full, all 8 outputs in order, none duplicated.
REQ-034 symb_numb_i=4, send 6 symbols -> 4 outputs, msg_done_o with 4th transfer, 5th/6th dropped, rotors back to key.
REQ-035 Key (0,25,0), send 0 -> with ENIGMA_DOUBLE_STEP_EN rotors (1,0,1), symbol_o 1; without, rotors (1,25,0), symbol_o 17.
